// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter_if
// Description : Bundle of requester-side and controller-side signals of the
//               three-port SDRAM command arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 26
);
    // Requester side (port n occupies bit/slice n)
    logic [2:0]              req_i;
    logic [2:0]              write_i;
    logic [3*ADDR_WIDTH-1:0] addr_i;
    logic [3*32-1:0]         wdata_i;
    logic [3*4-1:0]          wmask_i;
    logic [2:0]              ack_o;
    logic [2:0]              rvalid_o;
    logic [31:0]             rdata_o;
    logic                    err_o;

    // Controller side
    logic                    sd_req;
    logic                    sd_write;
    logic [ADDR_WIDTH-1:0]   sd_addr;
    logic [31:0]             sd_wdata;
    logic [3:0]              sd_wmask;
    logic                    sd_ready;
    logic                    sd_rvalid;
    logic [31:0]             sd_rdata;

    // Arbiter view
    modport slave (
        input  req_i, write_i, addr_i, wdata_i, wmask_i,
        input  sd_ready, sd_rvalid, sd_rdata,
        output ack_o, rvalid_o, rdata_o, err_o,
        output sd_req, sd_write, sd_addr, sd_wdata, sd_wmask
    );

    // Environment view (requesters plus controller)
    modport master (
        output req_i, write_i, addr_i, wdata_i, wmask_i,
        output sd_ready, sd_rvalid, sd_rdata,
        input  ack_o, rvalid_o, rdata_o, err_o,
        input  sd_req, sd_write, sd_addr, sd_wdata, sd_wmask
    );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Shares one SDRAM controller command port between VGA (port 0,
//               fixed priority) and CPU ifetch/data (ports 1/2, round-robin).
//               Read data is steered back via an in-order owner-tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_DEPTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    sdram_arbiter_if.slave   bus
);
    localparam int c_PTR_W = $clog2(TAG_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 2;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(TAG_DEPTH);

    // Command register towards the controller
    logic                  r_sd_req;
    logic                  r_sd_write;
    logic [ADDR_WIDTH-1:0] r_sd_addr;
    logic [31:0]           r_sd_wdata;
    logic [3:0]            r_sd_wmask;
    logic [1:0]            r_sd_port;
    // 1 when port 2 received the most recent 1-vs-2 slot
    logic                  r_last_was_p2;
    logic                  r_err;

    // Owner-tag FIFO
    logic [1:0]            r_tag_mem [TAG_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_accept;
    logic                  w_load;
    logic [c_CNT_W-1:0]    w_outstanding;
    logic                  w_read_room;
    logic [2:0]            w_eligible;
    logic [2:0]            w_grant;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_head;

    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic [3:0]            w_sel_wmask;
    logic [1:0]            w_sel_port;

    assign w_accept      = r_sd_req & bus.sd_ready;
    assign w_load        = ~r_sd_req | bus.sd_ready;
    // A read sitting in the register already claims a tag slot
    assign w_outstanding = r_count + c_CNT_W'(r_sd_req & ~r_sd_write);
    assign w_read_room   = (w_outstanding < c_DEPTH);
    assign w_eligible    = bus.req_i & (bus.write_i | {3{w_read_room}});

    assign w_fifo_empty  = (r_count == '0);
    assign w_fifo_full   = (r_count == c_DEPTH);
    assign w_pop         = bus.sd_rvalid & ~w_fifo_empty;
    assign w_push        = w_accept & ~r_sd_write & (~w_fifo_full | w_pop);
    assign w_head        = r_tag_mem[r_rd_ptr];

    // Winner selection: port 0 first, then round-robin between ports 1 and 2
    always_comb begin
        w_grant = 3'b000;
        if (w_load && !reset) begin
            if (w_eligible[0]) begin
                w_grant = 3'b001;
            end else if (w_eligible[1] && w_eligible[2]) begin
                w_grant = r_last_was_p2 ? 3'b010 : 3'b100;
            end else if (w_eligible[1]) begin
                w_grant = 3'b010;
            end else if (w_eligible[2]) begin
                w_grant = 3'b100;
            end
        end
    end

    // Gather the granted port's command fields
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wmask = '0;
        w_sel_port  = 2'd0;
        for (int n = 0; n < 3; n++) begin
            if (w_grant[n]) begin
                w_sel_write = bus.write_i[n];
                w_sel_addr  = bus.addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.wdata_i[n*32 +: 32];
                w_sel_wmask = bus.wmask_i[n*4 +: 4];
                w_sel_port  = 2'(n);
            end
        end
    end

    // Command register: load a grant, otherwise empty on acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sd_req   <= 1'b0;
            r_sd_write <= 1'b0;
            r_sd_addr  <= '0;
            r_sd_wdata <= '0;
            r_sd_wmask <= '0;
            r_sd_port  <= 2'd0;
        end else if (|w_grant) begin
            r_sd_req   <= 1'b1;
            r_sd_write <= w_sel_write;
            r_sd_addr  <= w_sel_addr;
            r_sd_wdata <= w_sel_wdata;
            r_sd_wmask <= w_sel_wmask;
            r_sd_port  <= w_sel_port;
        end else if (w_accept) begin
            r_sd_req   <= 1'b0;
        end
    end

    // Round-robin pointer moves only on port 1/2 grants; sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_was_p2 <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            if (w_grant[1]) r_last_was_p2 <= 1'b0;
            if (w_grant[2]) r_last_was_p2 <= 1'b1;
            if (bus.sd_rvalid && w_fifo_empty) r_err <= 1'b1;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage: owner port of each accepted read
    always_ff @(posedge clock) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= r_sd_port;
    end

    assign bus.ack_o    = w_grant;
    assign bus.rvalid_o = (w_pop && !reset) ? (3'b001 << w_head) : 3'b000;
    assign bus.rdata_o  = bus.sd_rdata;
    assign bus.err_o    = r_err;
    assign bus.sd_req   = r_sd_req;
    assign bus.sd_write = r_sd_write;
    assign bus.sd_addr  = r_sd_addr;
    assign bus.sd_wdata = r_sd_wdata;
    assign bus.sd_wmask = r_sd_wmask;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Randomized scoreboard bench for sdram_arbiter with a
//               queue-based reference model of requesters and controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int AW = 26;
    localparam int TD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sdram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    sdram_arbiter #(.ADDR_WIDTH(AW), .TAG_DEPTH(TD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          chk_reg;
        logic          chk_fields;
        logic [2:0]    ack;
        logic [2:0]    rvalid;
        logic [31:0]   rdata;
        logic          sd_req;
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Requester state
    bit          p_pend [3];
    bit          p_wr   [3];
    logic [AW-1:0] p_addr [3];
    logic [31:0] p_wdata[3];
    logic [3:0]  p_wmask[3];

    // Reference model state
    bit          m_valid;
    bit          m_wr;
    int          m_port;
    logic [AW-1:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    bit          m_just_reset;
    bit          m_err;
    int          last_rr;
    int          tags[$];

    // Controller model: due cycle of each read in flight, in issue order
    int          rv_due[$];

    // Phase knobs
    logic [2:0]  cfg_mask;
    int cfg_req, cfg_wr, cfg_rdy, cfg_dmin, cfg_dmax, cfg_rv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_port = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_just_reset = 1; m_err = 0; last_rr = 2;
        tags.delete();
    endtask

    // One clock of stimulus plus reference-model step
    task automatic step(input bit rst_now);
        exp_t e;
        int   win;
        int   outst;
        bit   el[3];
        bit   acc;
        @(negedge clock);
        cyc++;
        for (int n = 0; n < 3; n++) begin
            if (rst_now) p_pend[n] = 0;
            else if (!p_pend[n] && cfg_mask[n] && $urandom_range(99) < cfg_req) begin
                p_pend[n]  = 1;
                p_wr[n]    = ($urandom_range(99) < cfg_wr);
                p_addr[n]  = AW'($urandom);
                p_wdata[n] = $urandom;
                p_wmask[n] = 4'($urandom);
            end
        end
        reset = rst_now;
        for (int n = 0; n < 3; n++) begin
            bus.req_i[n]                = p_pend[n];
            bus.write_i[n]              = p_wr[n];
            bus.addr_i[n*AW +: AW]      = p_addr[n];
            bus.wdata_i[n*32 +: 32]     = p_wdata[n];
            bus.wmask_i[n*4 +: 4]       = p_wmask[n];
        end
        bus.sd_ready  = ($urandom_range(99) < cfg_rdy);
        bus.sd_rvalid = 1'b0;
        bus.sd_rdata  = $urandom;
        if (!rst_now && rv_due.size() > 0 && cyc >= rv_due[0] && $urandom_range(99) < cfg_rv) begin
            bus.sd_rvalid = 1'b1;
            void'(rv_due.pop_front());
        end

        e = '0;
        if (rst_now) begin
            exp_q.push_back(e);
            model_reset();
            return;
        end

        outst = tags.size() + ((m_valid && !m_wr) ? 1 : 0);
        win = -1;
        if (!m_valid || bus.sd_ready) begin
            for (int n = 0; n < 3; n++) el[n] = p_pend[n] && (p_wr[n] || outst < TD);
            if (el[0])              win = 0;
            else if (el[1] && el[2]) win = (last_rr == 2) ? 1 : 2;
            else if (el[1])         win = 1;
            else if (el[2])         win = 2;
        end
        if (win >= 0) e.ack[win] = 1'b1;
        if (bus.sd_rvalid && tags.size() > 0) begin
            e.rvalid[tags[0]] = 1'b1;
            e.rdata = bus.sd_rdata;
        end
        e.chk_reg    = 1'b1;
        e.chk_fields = m_valid || m_just_reset;
        e.sd_req     = m_valid;
        e.wr         = m_wr;
        e.addr       = m_addr;
        e.wdata      = m_wdata;
        e.wmask      = m_wmask;
        e.err        = m_err;
        exp_q.push_back(e);

        acc = m_valid && bus.sd_ready;
        if (bus.sd_rvalid) begin
            if (tags.size() > 0) void'(tags.pop_front());
            else m_err = 1;
        end
        if (acc && !m_wr) begin
            tags.push_back(m_port);
            rv_due.push_back(cyc + $urandom_range(cfg_dmax, cfg_dmin));
        end
        if (win >= 0) begin
            m_valid = 1; m_wr = p_wr[win]; m_port = win;
            m_addr = p_addr[win]; m_wdata = p_wdata[win]; m_wmask = p_wmask[win];
            m_just_reset = 0;
            p_pend[win] = 0;
            if (win != 0) last_rr = win;
        end else if (acc) begin
            m_valid = 0;
        end
    endtask

    task automatic phase(input int cycles, input logic [2:0] mask, input int req, input int wr,
                         input int rdy, input int dmin, input int dmax, input int rv);
        cfg_mask = mask; cfg_req = req; cfg_wr = wr; cfg_rdy = rdy;
        cfg_dmin = dmin; cfg_dmax = dmax; cfg_rv = rv;
        for (int i = 0; i < cycles; i++) step(1'b0);
    endtask

    // Monitor: pop one expectation per cycle and compare against the DUT
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ack_o", 64'(bus.ack_o), 64'(e.ack));
                chk("rvalid_o", 64'(bus.rvalid_o), 64'(e.rvalid));
                if (e.rvalid != 3'b000) chk("rdata_o", 64'(bus.rdata_o), 64'(e.rdata));
                if (e.chk_reg) begin
                    chk("sd_req", 64'(bus.sd_req), 64'(e.sd_req));
                    chk("err_o", 64'(bus.err_o), 64'(e.err));
                    if (e.chk_fields) begin
                        chk("sd_write", 64'(bus.sd_write), 64'(e.wr));
                        chk("sd_addr", 64'(bus.sd_addr), 64'(e.addr));
                        chk("sd_wdata", 64'(bus.sd_wdata), 64'(e.wdata));
                        chk("sd_wmask", 64'(bus.sd_wmask), 64'(e.wmask));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1);
    end

    // Main stimulus sequence
    initial begin
        bus.req_i = '0; bus.write_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.wmask_i = '0;
        bus.sd_ready = 1'b0; bus.sd_rvalid = 1'b0; bus.sd_rdata = '0;
        for (int n = 0; n < 3; n++) p_pend[n] = 0;
        cfg_mask = 3'b000; cfg_req = 0; cfg_wr = 0; cfg_rdy = 100;
        cfg_dmin = 1; cfg_dmax = 1; cfg_rv = 100;
        model_reset();

        step(1'b1); step(1'b1);
        phase(3,   3'b000, 0,   0,   100, 3,  3,  100);   // idle after reset
        phase(12,  3'b010, 100, 0,   100, 3,  3,  100);   // port 1 reads
        phase(40,  3'b111, 100, 30,  100, 1,  4,  100);   // port 0 dominates
        phase(60,  3'b110, 100, 0,   100, 1,  3,  100);   // 1/2 alternating reads
        phase(40,  3'b100, 100, 100, 20,  1,  3,  100);   // writes under back-pressure
        phase(40,  3'b010, 100, 0,   100, 15, 15, 100);   // tag FIFO limit
        phase(300, 3'b111, 60,  40,  60,  1,  8,  70);    // mixed random traffic
        phase(40,  3'b000, 0,   0,   100, 1,  1,  100);   // drain
        phase(6,   3'b010, 100, 0,   100, 30, 30, 100);   // reads left in flight
        step(1'b1);                                        // reset mid-operation
        phase(45,  3'b000, 0,   0,   100, 1,  1,  100);   // stale data -> err_o
        step(1'b1);
        phase(150, 3'b111, 60,  40,  70,  1,  6,  80);    // traffic after recovery
        phase(40,  3'b000, 0,   0,   100, 1,  1,  100);

        @(negedge clock);
        @(negedge clock);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
